// File: rtl/piso_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serializer_pkg
//  Description : Shared types and helpers for the PISO serializer slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package serializer_pkg;

    // Two-state controller: waiting for a word, or shifting one out.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit-counter width for a WIDTH-bit word (WIDTH >= 2).
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage : serializer_pkg
`default_nettype wire

// File: rtl/piso_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer_if
//  Description : Parallel-word input and serial-bit output handshake bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface piso_serializer_if #(
    parameter int WIDTH = 4
);

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             sout_ready;
    logic             sout_last;
    logic             busy;

    // Environment side: supplies words, consumes serial bits.
    modport master (
        output din,
        output din_valid,
        output sout_ready,
        input  din_ready,
        input  sout,
        input  sout_valid,
        input  sout_last,
        input  busy
    );

    // Serializer side.
    modport slave (
        input  din,
        input  din_valid,
        input  sout_ready,
        output din_ready,
        output sout,
        output sout_valid,
        output sout_last,
        output busy
    );

endinterface : piso_serializer_if
`default_nettype wire

// File: rtl/piso_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : piso_bit_counter
//  Description : Counts serial beats within a word; flags the final bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_bit_counter
    import serializer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [CW-1:0] bit_cnt;

    // Clear on word load takes priority over a beat so a new word starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (clear) begin
            bit_cnt <= '0;
        end else if (enable) begin
            bit_cnt <= bit_cnt + CW'(1);
        end
    end

    assign terminal = (bit_cnt == LAST_IDX);

endmodule : piso_bit_counter
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer
//  Description : Parallel-in/serial-out stage with valid/ready on both sides
//                and zero-bubble word streaming.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    piso_serializer_if.slave     bus
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic             out_bit;
    logic             terminal;
    logic             in_shift;
    logic             last_bit;
    logic             beat;
    logic             accept;

    assign in_shift = (state == SHIFT);
    assign last_bit = in_shift & terminal;
    assign beat     = in_shift & bus.sout_ready;
    // Ready during the final beat lets the next word load with no gap.
    assign accept   = bus.din_valid & bus.din_ready;

    // Shift direction and output tap depend on elaboration-time word order.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shift_next = {shift_reg[WIDTH-2:0], 1'b0};
            assign out_bit    = shift_reg[WIDTH-1];
        end else begin : g_lsb_first
            assign shift_next = {1'b0, shift_reg[WIDTH-1:1]};
            assign out_bit    = shift_reg[0];
        end
    endgenerate

    piso_bit_counter #(
        .WIDTH    (WIDTH)
    ) u_bit_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept),
        .enable   (beat),
        .terminal (terminal)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave IDLE on a word, leave SHIFT only at a last beat with nothing queued.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.din_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (beat && terminal) begin
                    state_next = bus.din_valid ? SHIFT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift register: load on accept, otherwise advance one position per beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
        end else if (accept) begin
            shift_reg <= bus.din;
        end else if (beat) begin
            shift_reg <= shift_next;
        end
    end

    assign bus.din_ready  = ~in_shift | (last_bit & bus.sout_ready);
    assign bus.sout       = out_bit;
    assign bus.sout_valid = in_shift;
    assign bus.sout_last  = last_bit;
    assign bus.busy       = in_shift;

endmodule : piso_serializer
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_serializer
//  Description : Scoreboard bench for piso_serializer, MSB-first and
//                LSB-first instances driven by identical stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] din;
    logic         din_valid;
    logic         sout_ready;

    int checks = 0;
    int errors = 0;

    // Expected beats: {msb-first bit, lsb-first bit, last flag}.
    logic [2:0] exp_q[$];
    logic       exp_ready;
    logic       has;
    logic [2:0] head;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(W)) ifm ();
    piso_serializer_if #(.WIDTH(W)) ifl ();

    assign ifm.din        = din;
    assign ifm.din_valid  = din_valid;
    assign ifm.sout_ready = sout_ready;
    assign ifl.din        = din;
    assign ifl.din_valid  = din_valid;
    assign ifl.sout_ready = sout_ready;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifm.slave)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifl.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_inst(input string tag, input logic dr, input logic sv, input logic s,
                              input logic sl, input logic b, input logic er, input logic hv,
                              input logic eb, input logic el);
        chk({tag, "_din_ready"},  {31'd0, dr}, {31'd0, er});
        chk({tag, "_sout_valid"}, {31'd0, sv}, {31'd0, hv});
        chk({tag, "_busy"},       {31'd0, b},  {31'd0, hv});
        chk({tag, "_sout"},       {31'd0, s},  {31'd0, eb});
        chk({tag, "_sout_last"},  {31'd0, sl}, {31'd0, el});
    endtask

    // Reference model + monitor: the serial line must replay each accepted word bit by bit.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            check_inst("rst_msb", ifm.din_ready, ifm.sout_valid, ifm.sout, ifm.sout_last, ifm.busy,
                       1'b1, 1'b0, 1'b0, 1'b0);
            check_inst("rst_lsb", ifl.din_ready, ifl.sout_valid, ifl.sout, ifl.sout_last, ifl.busy,
                       1'b1, 1'b0, 1'b0, 1'b0);
        end else begin
            has       = (exp_q.size() > 0);
            head      = has ? exp_q[0] : 3'b000;
            exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && sout_ready);
            check_inst("msb", ifm.din_ready, ifm.sout_valid, ifm.sout, ifm.sout_last, ifm.busy,
                       exp_ready, has, head[2], head[0]);
            check_inst("lsb", ifl.din_ready, ifl.sout_valid, ifl.sout, ifl.sout_last, ifl.busy,
                       exp_ready, has, head[1], head[0]);
            if (has && sout_ready) begin
                void'(exp_q.pop_front());
            end
            if (din_valid && exp_ready) begin
                for (int i = 0; i < W; i++) begin
                    exp_q.push_back({din[W-1-i], din[i], (i == W - 1)});
                end
            end
        end
    end

    // Present a word and hold it until the handshake completes; returns just after the accepting edge.
    task automatic send_word(input logic [W-1:0] w);
        bit done;
        done      = 1'b0;
        din       = w;
        din_valid = 1'b1;
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clk);
            if (ifm.din_ready) done = 1'b1;
        end
        if (done) begin
            @(posedge clk);
            #1;
        end else begin
            chk("send_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic idle_cycles(input int n);
        din_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        sout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_cycles(2);

        // Single word, then confirm return to idle.
        send_word(4'b1010);
        idle_cycles(6);

        // Back-to-back streaming with valid held high.
        send_word(4'b1111);
        send_word(4'b0101);
        idle_cycles(6);

        // Backpressure after the second bit.
        send_word(4'b1100);
        din_valid = 1'b0;
        din       = 4'b0110;
        @(posedge clk); #1;
        @(posedge clk); #1;
        sout_ready = 1'b0;
        din        = 4'b1001;
        repeat (3) @(posedge clk);
        #1 sout_ready = 1'b1;
        idle_cycles(6);

        // Word whose order distinguishes MSB-first from LSB-first.
        send_word(4'b1000);
        idle_cycles(6);

        // Asynchronous reset in the middle of a word.
        send_word(4'b1111);
        din_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_msb_valid", {31'd0, ifm.sout_valid}, 32'd0);
        chk("async_rst_lsb_valid", {31'd0, ifl.sout_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_cycles(1);
        send_word(4'b0011);
        idle_cycles(6);

        // Randomized traffic: din changes every cycle, valid and ready toggle freely.
        for (int c = 0; c < 400; c++) begin
            din        = W'($urandom);
            din_valid  = ($urandom_range(0, 3) != 0);
            sout_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end

        // Drain and confirm every expected bit was delivered.
        sout_ready = 1'b1;
        idle_cycles(2 * W + 4);
        chk("drain_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_piso_serializer
`default_nettype wire
